// File: rtl/mat_vec_mac_pkg.sv
// rtl/mat_vec_mac_pkg.sv - shared Q-format constants, FSM encoding and round/bias/saturate helper
package mat_vec_mac_pkg;

  localparam int DEF_QN       = 6;
  localparam int DEF_QM       = 11;
  localparam int DEF_BITWIDTH = DEF_QN + DEF_QM + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_FINAL
  } state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < n) r = r + 1;
    end
    return r;
  endfunction

  // Round half up at QM, add bias, then clamp to bw-bit signed range when sat is set.
  function automatic logic signed [63:0] round_bias_sat(
    input logic signed [63:0] acc,
    input logic signed [63:0] bias,
    input int                 qm,
    input int                 bw,
    input bit                 sat
  );
    logic signed [63:0] v;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    v  = ((acc + (64'sd1 <<< (qm - 1))) >>> qm) + bias;
    hi = (64'sd1 <<< (bw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (bw - 1));
    if (sat) begin
      if (v > hi) v = hi;
      else if (v < lo) v = lo;
    end
    return v;
  endfunction

endpackage

// File: rtl/mat_vec_mac_lane.sv
// rtl/mat_vec_mac_lane.sv - one multiplier lane: memory-return register plus ROWS_PER_MAC accumulators
module mac_lane
  import mat_vec_mac_pkg::*;
#(
  parameter int BITWIDTH     = DEF_BITWIDTH,
  parameter int ACCW         = 2 * DEF_BITWIDTH + 2,
  parameter int ROWS_PER_MAC = 4,
  parameter int PW           = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         clear,
  input  logic                         valid,
  input  logic [PW-1:0]                phase,
  input  logic [ROWS_PER_MAC*BITWIDTH-1:0] weights,
  input  logic [BITWIDTH-1:0]          x,
  output logic [ROWS_PER_MAC*ACCW-1:0] acc
);

  logic signed [BITWIDTH-1:0]   w_q;
  logic signed [BITWIDTH-1:0]   x_q;
  logic                         valid_q;
  logic [PW-1:0]                phase_q;
  logic signed [2*BITWIDTH-1:0] prod;
  logic signed [ACCW-1:0]       acc_q [ROWS_PER_MAC];

  assign prod = w_q * x_q;

  // The weight of the row currently served is picked as the memory data returns.
  always_ff @(posedge clk) begin
    if (reset) begin
      w_q     <= '0;
      x_q     <= '0;
      valid_q <= 1'b0;
      phase_q <= '0;
      for (int i = 0; i < ROWS_PER_MAC; i++) acc_q[i] <= '0;
    end else begin
      valid_q <= valid;
      phase_q <= phase;
      if (valid) begin
        w_q <= weights[phase*BITWIDTH +: BITWIDTH];
        x_q <= x;
      end
      if (clear) begin
        for (int i = 0; i < ROWS_PER_MAC; i++) acc_q[i] <= '0;
      end else if (valid_q) begin
        acc_q[phase_q] <= acc_q[phase_q] + ACCW'(prod);
      end
    end
  end

  for (genvar g = 0; g < ROWS_PER_MAC; g++) begin : g_acc
    assign acc[g*ACCW +: ACCW] = acc_q[g];
  end

endmodule

// File: rtl/mat_vec_mac.sv
// rtl/mat_vec_mac.sv - restartable fixed-point y = sat(round(W*x) + b) engine with time-shared lanes
module mat_vec_mac
  import mat_vec_mac_pkg::*;
#(
  parameter int NROW         = 16,
  parameter int NCOL         = 4,
  parameter int QN           = 6,
  parameter int QM           = 11,
  parameter int ROWS_PER_MAC = 4,
  parameter int SATURATE     = 1,
  localparam int BITWIDTH    = QN + QM + 1,
  localparam int CW          = (clog2(NCOL) > 0) ? clog2(NCOL) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic [CW-1:0]            colAddress,
  input  logic [NROW*BITWIDTH-1:0] weightRow,
  input  logic [BITWIDTH-1:0]      inputVector,
  input  logic [NROW*BITWIDTH-1:0] biasVector,
  output logic [NROW*BITWIDTH-1:0] outputVector
);

  localparam int NLANE = NROW / ROWS_PER_MAC;
  localparam int ACCW  = 2 * BITWIDTH + clog2(NCOL);
  localparam int PW    = (clog2(ROWS_PER_MAC) > 0) ? clog2(ROWS_PER_MAC) : 1;

  state_t               state_q;
  state_t               state_d;
  logic [CW-1:0]        col;
  logic [PW-1:0]        phase;
  logic                 drain_cnt;
  logic                 last_col;
  logic                 last_issue;
  logic                 clear;
  logic                 v1;
  logic [PW-1:0]        p1;
  logic [NROW*ACCW-1:0] acc_all;
  logic [NROW*BITWIDTH-1:0] fin;

  assign last_col   = (col == CW'(NCOL - 1));
  assign last_issue = last_col && (phase == PW'(ROWS_PER_MAC - 1));
  assign clear      = (state_q == S_IDLE) && start;
  assign busy       = (state_q != S_IDLE);
  assign colAddress = col;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_ISSUE;
      S_ISSUE: if (last_issue) state_d = S_DRAIN;
      S_DRAIN: if (drain_cnt) state_d = S_FINAL;
      S_FINAL: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      col          <= '0;
      phase        <= '0;
      drain_cnt    <= 1'b0;
      done         <= 1'b0;
      v1           <= 1'b0;
      p1           <= '0;
      outputVector <= '0;
    end else begin
      state_q   <= state_d;
      done      <= (state_q == S_FINAL);
      v1        <= (state_q == S_ISSUE);
      p1        <= phase;
      drain_cnt <= (state_q == S_DRAIN) ? ~drain_cnt : 1'b0;
      if (state_q == S_ISSUE) begin
        if (last_col) begin
          col   <= '0;
          phase <= (phase == PW'(ROWS_PER_MAC - 1)) ? '0 : phase + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
      if (state_q == S_FINAL) outputVector <= fin;
    end
  end

  for (genvar i = 0; i < NLANE; i++) begin : g_lane
    mac_lane #(
      .BITWIDTH     (BITWIDTH),
      .ACCW         (ACCW),
      .ROWS_PER_MAC (ROWS_PER_MAC),
      .PW           (PW)
    ) u_lane (
      .clk     (clk),
      .reset   (reset),
      .clear   (clear),
      .valid   (v1),
      .phase   (p1),
      .weights (weightRow[i*ROWS_PER_MAC*BITWIDTH +: ROWS_PER_MAC*BITWIDTH]),
      .x       (inputVector),
      .acc     (acc_all[i*ROWS_PER_MAC*ACCW +: ROWS_PER_MAC*ACCW])
    );
  end

  for (genvar r = 0; r < NROW; r++) begin : g_final
    logic signed [ACCW-1:0]     acc_r;
    logic signed [BITWIDTH-1:0] b_r;
    assign acc_r = acc_all[r*ACCW +: ACCW];
    assign b_r   = biasVector[r*BITWIDTH +: BITWIDTH];
    assign fin[r*BITWIDTH +: BITWIDTH] =
      BITWIDTH'(round_bias_sat(64'(acc_r), 64'(b_r), QM, BITWIDTH, SATURATE != 0));
  end

endmodule

// File: tb/tb_mat_vec_mac.sv
// tb/tb_mat_vec_mac.sv - scoreboard bench for mat_vec_mac, saturating and wrapping builds side by side
module tb_mat_vec_mac;

  localparam int NROW = 4;
  localparam int NCOL = 2;
  localparam int RPM  = 2;
  localparam int BW   = 18;
  localparam int T    = NCOL * RPM;

  typedef struct packed {
    logic [NROW*BW-1:0] s;
    logic [NROW*BW-1:0] w;
  } exp_t;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic              busy_s, done_s, busy_w, done_w;
  logic [0:0]        col_s, col_w;
  logic [NROW*BW-1:0] weightRow;
  logic [BW-1:0]     inputVector;
  logic [NROW*BW-1:0] biasVector;
  logic [NROW*BW-1:0] out_s, out_w;

  int   w_m [NROW][NCOL];
  int   x_m [NCOL];
  int   b_m [NROW];
  exp_t sb [$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mat_vec_mac #(.NROW(NROW), .NCOL(NCOL), .QN(6), .QM(11), .ROWS_PER_MAC(RPM), .SATURATE(1)) dut_sat (
    .clk(clk), .reset(reset), .start(start), .busy(busy_s), .done(done_s), .colAddress(col_s),
    .weightRow(weightRow), .inputVector(inputVector), .biasVector(biasVector), .outputVector(out_s)
  );

  mat_vec_mac #(.NROW(NROW), .NCOL(NCOL), .QN(6), .QM(11), .ROWS_PER_MAC(RPM), .SATURATE(0)) dut_wrap (
    .clk(clk), .reset(reset), .start(start), .busy(busy_w), .done(done_w), .colAddress(col_w),
    .weightRow(weightRow), .inputVector(inputVector), .biasVector(biasVector), .outputVector(out_w)
  );

  // One-cycle read latency memories addressed by the DUT.
  always @(posedge clk) begin
    for (int r = 0; r < NROW; r++) weightRow[r*BW +: BW] <= BW'(w_m[r][col_s]);
    inputVector <= BW'(x_m[col_s]);
  end

  always_comb begin
    biasVector = '0;
    for (int r = 0; r < NROW; r++) biasVector[r*BW +: BW] = BW'(b_m[r]);
  end

  function automatic logic [NROW*BW-1:0] model(input bit sat);
    logic [NROW*BW-1:0] y;
    longint acc, v;
    y = '0;
    for (int r = 0; r < NROW; r++) begin
      acc = 0;
      for (int c = 0; c < NCOL; c++) acc += longint'(w_m[r][c]) * longint'(x_m[c]);
      v = ((acc + 1024) >>> 11) + longint'(b_m[r]);
      if (sat) begin
        if (v > 131071) v = 131071;
        if (v < -131072) v = -131072;
      end
      y[r*BW +: BW] = BW'(v);
    end
    return y;
  endfunction

  task automatic check(input string tag, input logic [NROW*BW-1:0] obs, input logic [NROW*BW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_data();
    for (int r = 0; r < NROW; r++) begin
      b_m[r] = 0;
      for (int c = 0; c < NCOL; c++) w_m[r][c] = 0;
    end
    for (int c = 0; c < NCOL; c++) x_m[c] = 0;
  endtask

  // Starts a run (start raised before the sampling edge) and checks it through done.
  task automatic run(input string tag, input bit hold, input int pulse_at);
    int   cnt;
    exp_t e;
    sb.push_back('{s: model(1'b1), w: model(1'b0)});
    start = 1'b1;
    @(negedge clk);
    if (!hold) start = 1'b0;
    cnt = 1;
    while (cnt < 20 && !done_s) begin
      if (cnt <= T) check({tag, "_col"}, (NROW*BW)'(col_s), (NROW*BW)'((cnt - 1) % NCOL));
      if (cnt == 1) check({tag, "_busy"}, (NROW*BW)'(busy_s), (NROW*BW)'(1));
      if (cnt == pulse_at) start = 1'b1;
      else if (!hold) start = 1'b0;
      @(negedge clk);
      cnt++;
    end
    check({tag, "_latency"}, (NROW*BW)'(cnt), (NROW*BW)'(T + 4));
    check({tag, "_done_busy"}, (NROW*BW)'({done_s, busy_s, done_w}), (NROW*BW)'(3'b101));
    e = sb.pop_front();
    check({tag, "_y_sat"}, out_s, e.s);
    check({tag, "_y_wrap"}, out_w, e.w);
  endtask

  initial begin
    int  quiet;
    reset = 1'b1;
    start = 1'b0;
    clear_data();
    repeat (3) @(negedge clk);
    check("reset_state", (NROW*BW)'({busy_s, done_s, col_s}), '0);
    check("reset_out", out_s, '0);
    reset = 1'b0;
    @(negedge clk);

    w_m[0][0] = 2048; w_m[1][1] = 2048;
    x_m[0] = 1024; x_m[1] = -512;
    check("identity_model", model(1'b1), {18'd0, 18'd0, 18'h3fe00, 18'd1024});
    run("identity", 1'b0, 0);

    clear_data();
    w_m[0][0] = 3072; w_m[1][0] = -3072; x_m[0] = 1;
    run("round", 1'b0, 0);

    for (int r = 0; r < NROW; r++) for (int c = 0; c < NCOL; c++) w_m[r][c] = 129024;
    x_m[0] = 129024; x_m[1] = 129024;
    run("saturate", 1'b0, 0);

    clear_data();
    b_m[0] = 1; b_m[1] = -1; b_m[2] = 131071; b_m[3] = -131072;
    run("bias", 1'b0, 0);

    for (int r = 0; r < NROW; r++) begin
      w_m[r][0] = 2048;
      b_m[r]    = 131071;
    end
    x_m[0] = 2048;
    run("bias_max", 1'b0, 0);

    clear_data();
    w_m[0][1] = 4096; w_m[3][0] = -2048; w_m[2][1] = 1000;
    x_m[0] = 700; x_m[1] = -300; b_m[1] = 5;
    run("b2b_0", 1'b1, 0);
    run("b2b_1", 1'b1, 0);
    run("b2b_2", 1'b0, 3);

    quiet = 1;
    repeat (10) begin
      @(negedge clk);
      if (done_s || busy_s) quiet = 0;
    end
    check("ignored_start_quiet", (NROW*BW)'(quiet), (NROW*BW)'(1));

    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("abort_state", (NROW*BW)'({busy_s, done_s, col_s, busy_w, done_w}), '0);
    check("abort_out", out_s, '0);
    reset = 1'b0;
    quiet = 1;
    repeat (8) begin
      @(negedge clk);
      if (done_s || busy_s) quiet = 0;
    end
    check("abort_no_done", (NROW*BW)'(quiet), (NROW*BW)'(1));

    clear_data();
    w_m[0][0] = 2048; w_m[1][1] = 2048; w_m[2][0] = 1024; w_m[3][1] = -1024;
    x_m[0] = 3000; x_m[1] = -1500; b_m[2] = 7;
    run("after_abort", 1'b0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
